// File: rtl/psum_pkg.sv
// Shared psum definitions: width helpers, pipeline sideband layout and the
// round-half-up/saturate arithmetic also used by the psum writeback path.
package psum_pkg;

    localparam int PSUM_IN_FRAC_DEFAULT  = 10;
    localparam int PSUM_OUT_FRAC_DEFAULT = 10;
    localparam int PSUM_SB_W             = 3;

    typedef enum logic [0:0] {
        GRP_IDLE = 1'b0,
        GRP_ACC  = 1'b1
    } grp_state_t;

    typedef struct packed {
        logic valid;
        logic last;
        logic mode;
    } psum_sb_t;

    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

    // Operand count entering tree level j (odd counts round up: zero padded).
    function automatic int lvl_cnt(input int n, input int j);
        return (n + (32'sd1 <<< j) - 32'sd1) >>> j;
    endfunction

    // Bit offset of level j's operand vector inside the flattened tree bus.
    function automatic int lvl_off(input int n, input int w, input int j);
        int off;
        off = 32'sd0;
        for (int i = 0; i < j; i++) begin
            off = off + lvl_cnt(n, i) * (w + i);
        end
        return off;
    endfunction

    function automatic logic signed [63:0] psum_round(input logic signed [63:0] acc,
                                                      input int sh);
        logic signed [63:0] bias;
        bias = (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
        return (acc + bias) >>> sh;
    endfunction

    function automatic logic signed [63:0] psum_round_sat(input logic signed [63:0] acc,
                                                          input int sh, input int out_width);
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        r     = psum_round(acc, sh);
        max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        if (r > max_v) begin
            return max_v;
        end else if (r < (-max_v - 64'sd1)) begin
            return -max_v - 64'sd1;
        end else begin
            return r;
        end
    endfunction

    function automatic logic psum_sat_flag(input logic signed [63:0] acc,
                                           input int sh, input int out_width);
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        r     = psum_round(acc, sh);
        max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        return (r > max_v) || (r < (-max_v - 64'sd1));
    endfunction

endpackage

// File: rtl/psum_tree_level.sv
// One registered pairwise-add level of the psum reduction tree; an odd
// leftover operand is added to a constant zero.
module psum_tree_level
    import psum_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int W_IN  = 16,
    localparam int N_OUT = (N_IN + 1) / 2,
    localparam int W_OUT = W_IN + 1
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [N_IN*W_IN-1:0]     opnd,
    input  logic [PSUM_SB_W-1:0]     opnd_sb,
    output logic [N_OUT*W_OUT-1:0]   sum,
    output logic [PSUM_SB_W-1:0]     sum_sb
);

    logic signed [W_IN-1:0]  pad_s [0:2*N_OUT-1];
    logic [N_OUT*W_OUT-1:0]  sum_s;
    logic [N_OUT*W_OUT-1:0]  sum_r;
    logic [PSUM_SB_W-1:0]    sb_r;

    genvar k;
    for (k = 0; k < 2 * N_OUT; k++) begin : g_pad
        if (k < N_IN) begin : g_opnd
            assign pad_s[k] = opnd[k*W_IN +: W_IN];
        end else begin : g_zero
            assign pad_s[k] = {W_IN{1'b0}};
        end
    end

    for (k = 0; k < N_OUT; k++) begin : g_add
        assign sum_s[k*W_OUT +: W_OUT] = W_OUT'(pad_s[2*k]) + W_OUT'(pad_s[2*k+1]);
    end

    // Level register: data and sideband advance together on every enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_r <= '0;
            sb_r  <= '0;
        end else if (en) begin
            sum_r <= sum_s;
            sb_r  <= opnd_sb;
        end
    end

    assign sum    = sum_r;
    assign sum_sb = sb_r;

endmodule

// File: rtl/psum_adder_tree.sv
// Pipelined signed adder tree with optional group accumulation and a
// round-half-up / saturating output stage feeding psum writeback.
module psum_adder_tree
    import psum_pkg::*;
#(
    parameter int INWIDTH    = 16,
    parameter int IN_FRAC    = PSUM_IN_FRAC_DEFAULT,
    parameter int NUM_INPUTS = 45,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_FRAC   = PSUM_OUT_FRAC_DEFAULT,
    parameter int ACC_GUARD  = 8
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [INWIDTH*NUM_INPUTS-1:0] din,
    input  logic                          din_valid,
    input  logic                          din_last,
    input  logic                          acc_mode,
    output logic [OUT_WIDTH-1:0]          dout,
    output logic                          dout_valid,
    output logic                          dout_sat
);

    localparam int L     = clog2(NUM_INPUTS);
    localparam int SUMW  = INWIDTH + L;
    localparam int ACCW  = SUMW + ACC_GUARD;
    localparam int SH    = IN_FRAC - OUT_FRAC;
    localparam int BUSW  = lvl_off(NUM_INPUTS, INWIDTH, L + 1);
    localparam int OFF_L = lvl_off(NUM_INPUTS, INWIDTH, L);

    // Every level's operand vector lives in one flat bus, level 0 being din.
    logic [BUSW-1:0]              bus_s;
    logic [PSUM_SB_W*(L+1)-1:0]   sb_bus_s;
    logic signed [SUMW-1:0]       tree_sum_s;
    psum_sb_t                     tree_sb_s;

    logic signed [ACCW-1:0]       sum_ext_s;
    logic signed [ACCW-1:0]       acc_nxt_s;
    logic signed [ACCW-1:0]       acc_r;
    grp_state_t                   state_nxt_s;
    grp_state_t                   state_r;
    logic                         emit_nxt_s;
    logic                         emit_r;

    logic [OUT_WIDTH-1:0]         rnd_val_s;
    logic                         rnd_sat_s;
    logic [OUT_WIDTH-1:0]         dout_r;
    logic                         dout_valid_r;
    logic                         dout_sat_r;

    assign bus_s[INWIDTH*NUM_INPUTS-1:0] = din;
    assign sb_bus_s[PSUM_SB_W-1:0]       = {din_valid, din_last, acc_mode};

    genvar j;
    for (j = 0; j < L; j++) begin : g_lvl
        localparam int NI    = lvl_cnt(NUM_INPUTS, j);
        localparam int NO    = lvl_cnt(NUM_INPUTS, j + 1);
        localparam int OFF_I = lvl_off(NUM_INPUTS, INWIDTH, j);
        localparam int OFF_O = lvl_off(NUM_INPUTS, INWIDTH, j + 1);

        psum_tree_level #(
            .N_IN (NI),
            .W_IN (INWIDTH + j)
        ) u_level (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .opnd    (bus_s[OFF_I +: NI*(INWIDTH+j)]),
            .opnd_sb (sb_bus_s[PSUM_SB_W*j +: PSUM_SB_W]),
            .sum     (bus_s[OFF_O +: NO*(INWIDTH+j+1)]),
            .sum_sb  (sb_bus_s[PSUM_SB_W*(j+1) +: PSUM_SB_W])
        );
    end

    assign tree_sum_s = bus_s[OFF_L +: SUMW];
    assign tree_sb_s  = sb_bus_s[PSUM_SB_W*L +: PSUM_SB_W];
    assign sum_ext_s  = ACCW'(tree_sum_s);

    // Group FSM and accumulator next-state; a mode-0 vector aborts an open group.
    always_comb begin
        acc_nxt_s   = acc_r;
        state_nxt_s = state_r;
        emit_nxt_s  = 1'b0;
        if (tree_sb_s.valid) begin
            if (tree_sb_s.mode) begin
                case (state_r)
                    GRP_IDLE: acc_nxt_s = sum_ext_s;
                    GRP_ACC:  acc_nxt_s = acc_r + sum_ext_s;
                    default:  acc_nxt_s = sum_ext_s;
                endcase
                if (tree_sb_s.last) begin
                    emit_nxt_s  = 1'b1;
                    state_nxt_s = GRP_IDLE;
                end else begin
                    emit_nxt_s  = 1'b0;
                    state_nxt_s = GRP_ACC;
                end
            end else begin
                acc_nxt_s   = sum_ext_s;
                emit_nxt_s  = 1'b1;
                state_nxt_s = GRP_IDLE;
            end
        end else begin
            emit_nxt_s = 1'b0;
        end
    end

    // Accumulate stage and group state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r   <= '0;
            state_r <= GRP_IDLE;
            emit_r  <= 1'b0;
        end else if (en) begin
            acc_r   <= acc_nxt_s;
            state_r <= state_nxt_s;
            emit_r  <= emit_nxt_s;
        end
    end

    assign rnd_val_s = OUT_WIDTH'(psum_round_sat(64'(acc_r), SH, OUT_WIDTH));
    assign rnd_sat_s = psum_sat_flag(64'(acc_r), SH, OUT_WIDTH);

    // Output stage: result and flag only move when a new strobe is produced.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            dout_sat_r   <= 1'b0;
        end else if (en) begin
            dout_valid_r <= emit_r;
            if (emit_r) begin
                dout_r     <= rnd_val_s;
                dout_sat_r <= rnd_sat_s;
            end
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign dout_sat   = dout_sat_r;

endmodule

// File: tb/tb_psum_adder_tree.sv
// Scoreboard bench for psum_adder_tree: two instances (OUT_FRAC 10 and 8)
// share stimulus; expected results are queued at drive time.
module tb_psum_adder_tree;

    localparam int N   = 45;
    localparam int W   = 16;
    localparam int LAT = 8;

    typedef struct {
        longint val;
        bit     sat;
        longint due;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic [W*N-1:0] din;
    logic           din_valid;
    logic           din_last;
    logic           acc_mode;
    logic [15:0]    dout10, dout8;
    logic           dv10, dv8, ds10, ds8;

    exp_t   q10[$];
    exp_t   q8[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint en_cnt   = 0;
    bit     en_edge  = 1'b0;
    bit     rst_edge = 1'b1;
    longint last10   = 0;
    longint last8    = 0;
    longint grp_acc  = 0;
    bit     grp_open = 1'b0;

    always #5 clk = ~clk;

    psum_adder_tree #(.OUT_FRAC(10)) u_dut10 (
        .clk(clk), .reset(reset), .en(en), .din(din), .din_valid(din_valid),
        .din_last(din_last), .acc_mode(acc_mode),
        .dout(dout10), .dout_valid(dv10), .dout_sat(ds10)
    );

    psum_adder_tree #(.OUT_FRAC(8)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .din(din), .din_valid(din_valid),
        .din_last(din_last), .acc_mode(acc_mode),
        .dout(dout8), .dout_valid(dv8), .dout_sat(ds8)
    );

    task automatic chk_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input longint acc, input int sh, input longint due);
        exp_t   e;
        longint r;
        r = acc;
        if (sh > 0) r = r + (64'sd1 <<< (sh - 1));
        r = r >>> sh;
        e.due = due;
        if (r > 32767) begin
            e.val = 32767;  e.sat = 1'b1;
        end else if (r < -32768) begin
            e.val = -32768; e.sat = 1'b1;
        end else begin
            e.val = r;      e.sat = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        en_edge  <= en;
        rst_edge <= reset;
        en_cnt   <= en_cnt + (en ? 64'sd1 : 64'sd0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) begin
            last10 <= 0;
        end else if (en_edge) begin
            if (dv10) begin
                if (q10.size() == 0) begin
                    chk_eq("strobe10_expected", q10.size(), 1);
                end else begin
                    e = q10.pop_front();
                    chk_eq("dout10", longint'($signed(dout10)), e.val);
                    chk_eq("sat10", longint'(ds10), longint'(e.sat));
                    chk_eq("latency10", en_cnt, e.due);
                    last10 <= e.val;
                end
            end else begin
                chk_eq("hold10", longint'($signed(dout10)), last10);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) begin
            last8 <= 0;
        end else if (en_edge) begin
            if (dv8) begin
                if (q8.size() == 0) begin
                    chk_eq("strobe8_expected", q8.size(), 1);
                end else begin
                    e = q8.pop_front();
                    chk_eq("dout8", longint'($signed(dout8)), e.val);
                    chk_eq("sat8", longint'(ds8), longint'(e.sat));
                    chk_eq("latency8", en_cnt, e.due);
                    last8 <= e.val;
                end
            end else begin
                chk_eq("hold8", longint'($signed(dout8)), last8);
            end
        end
    end

    // use_fill=1: every operand equals val; otherwise random operands summing to val.
    task automatic send(input bit use_fill, input int val, input bit mode, input bit last);
        int     ops[N];
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) begin
            if (use_fill) ops[k] = val;
            else if (k < N - 1) ops[k] = int'($urandom_range(200)) - 100;
            else ops[k] = val - int'(s);
            s = s + ops[k];
        end
        for (int k = 0; k < N; k++) din[k*W +: W] = 16'(ops[k]);
        din_valid = 1'b1;
        din_last  = last;
        acc_mode  = mode;
        en        = 1'b1;
        if (!mode) begin
            q10.push_back(model(s, 0, en_cnt + LAT));
            q8.push_back(model(s, 2, en_cnt + LAT));
            grp_open = 1'b0;
        end else begin
            grp_acc = grp_open ? grp_acc + s : s;
            if (last) begin
                q10.push_back(model(grp_acc, 0, en_cnt + LAT));
                q8.push_back(model(grp_acc, 2, en_cnt + LAT));
                grp_open = 1'b0;
            end else begin
                grp_open = 1'b1;
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        din_last  = 1'b0;
        acc_mode  = 1'b0;
    endtask

    task automatic stall(input int n);
        en = 1'b0;
        repeat (n) @(negedge clk);
        en = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q10.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        chk_eq("drain10", q10.size(), 0);
        chk_eq("drain8", q8.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        en        = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        din_last  = 1'b0;
        acc_mode  = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("reset_dout10", longint'(dout10), 0);
        chk_eq("reset_valid10", longint'(dv10), 0);
        chk_eq("reset_sat8", longint'(ds8), 0);
        reset = 1'b0;
        @(negedge clk);

        // single vector, then saturation both ways
        send(1'b1, 512, 1'b0, 1'b0);
        drain();
        send(1'b1, 1024, 1'b0, 1'b0);
        send(1'b1, -1024, 1'b0, 1'b0);
        drain();

        // accumulate group of three, then a single-vector group
        send(1'b0, 100, 1'b1, 1'b0);
        send(1'b0, 200, 1'b1, 1'b0);
        send(1'b0, -50, 1'b1, 1'b1);
        send(1'b0, 9, 1'b1, 1'b1);
        drain();

        // mixed modes with a stall in the middle of the stream
        send(1'b0, 300, 1'b0, 1'b0);
        send(1'b0, 11, 1'b1, 1'b0);
        stall(2);
        send(1'b0, 22, 1'b1, 1'b1);
        send(1'b0, -5, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        stall(2);
        drain();

        // open group aborted by a mode-0 vector
        send(1'b0, 40, 1'b1, 1'b0);
        send(1'b0, 7, 1'b0, 1'b0);
        drain();

        // random burst with occasional stalls
        for (int i = 0; i < 24; i++) begin
            send(1'b0, int'($urandom_range(4000)) - 2000, 1'($urandom_range(1)),
                 ($urandom_range(2) == 0));
            if ($urandom_range(4) == 0) stall(1);
        end
        drain();

        // reset with four vectors in flight
        for (int i = 0; i < 4; i++) send(1'b0, 1000 + i, 1'b0, 1'b0);
        reset = 1'b1;
        q10.delete();
        q8.delete();
        grp_open = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk_eq("midreset_dout10", longint'(dout10), 0);
        chk_eq("midreset_valid10", longint'(dv10), 0);
        chk_eq("midreset_sat10", longint'(ds10), 0);
        chk_eq("midreset_dout8", longint'(dout8), 0);
        chk_eq("midreset_valid8", longint'(dv8), 0);
        repeat (12) @(negedge clk);
        drain();

        // rounding at OUT_FRAC=8: half rounds up
        send(1'b0, 2, 1'b0, 1'b0);
        send(1'b0, 1, 1'b0, 1'b0);
        send(1'b0, -2, 1'b0, 1'b0);
        send(1'b0, -3, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
